// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module mult_div_unit (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        HiLd,
  output logic        LoLd,
  output logic        DivZero,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_p0, state_nx;
  logic [4:0]  cnt_p0;
  logic        accept;

  logic        is_div_p0, neg_q_p0, neg_r_p0, dz_p0;
  logic [31:0] a_raw_p0, d_p0, lo_p0, hi_p0;

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Magnitude of a 32-bit operand; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
    logic signed [31:0] n;
    n = -v;
    return (is_signed && v < 0) ? n : v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign accept = (state_p0 == IDLE) && Start;

  always_ff @(posedge Clk) begin
    if (Clr) state_p0 <= IDLE;
    else     state_p0 <= state_nx;
  end

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (Start) state_nx = CALC;
      CALC:    if (cnt_p0 == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_p0 != IDLE);
  end

  assign HiLd = Done;
  assign LoLd = Done;

  // Operand capture and per-cycle iteration
  always_ff @(posedge Clk) begin
    if (accept) begin
      a_raw_p0  <= A;
      hi_p0     <= 32'd0;
      lo_p0     <= mag32(A, ~Op[0]);
      d_p0      <= mag32(B, ~Op[0]);
      is_div_p0 <= Op[1];
      neg_q_p0  <= ~Op[0] & (A[31] ^ B[31]);
      neg_r_p0  <= ~Op[0] & A[31];
      dz_p0     <= Op[1] && (B == 32'd0);
    end else if (state_p0 == CALC) begin
      if (is_div_p0) begin
        hi_p0 <= div_ge ? div_rem : div_sh[31:0];
        lo_p0 <= {lo_p0[30:0], div_ge};
      end else begin
        hi_p0 <= mul_sum[32:1];
        lo_p0 <= {mul_sum[0], lo_p0[31:1]};
      end
    end
  end

  // Partial remainder is always below the divisor, so the 32-bit subtraction is exact.
  always_comb begin
    mul_sum = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, d_p0} : 33'd0);
    div_sh  = {hi_p0, lo_p0[31]};
    div_ge  = (div_sh >= {1'b0, d_p0});
    div_rem = div_sh[31:0] - d_p0;
  end

  always_comb begin
    prod   = cneg64({hi_p0, lo_p0}, neg_q_p0);
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (dz_p0) begin
      res_hi = a_raw_p0;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div_p0) begin
      res_hi = cneg32(hi_p0, neg_r_p0);
      res_lo = cneg32(lo_p0, neg_q_p0);
    end
  end

  // Completion stage: result registers and one-cycle strobes
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cnt_p0  <= 5'd0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HiOut   <= 32'd0;
      LoOut   <= 32'd0;
    end else begin
      Done    <= (state_p0 == FIX);
      DivZero <= (state_p0 == FIX) && dz_p0;
      if (accept)                 cnt_p0 <= 5'd0;
      else if (state_p0 == CALC)  cnt_p0 <= cnt_p0 + 5'd1;
      if (state_p0 == FIX) begin
        HiOut <= res_hi;
        LoOut <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected results, monitor checks on Done.
module tb_mult_div_unit;

  logic        Clk, Clr, Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, HiLd, LoLd, DivZero;
  logic [31:0] HiOut, LoOut;

  mult_div_unit dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HiLd(HiLd), .LoLd(LoLd), .DivZero(DivZero),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t scb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  logic start_in_done;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: 64-bit integer arithmetic straight from the operation definitions.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = 64'd0;
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p  = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz);
    int g;
    exp_t e;
    g = 0;
    @(negedge Clk);
    while (Busy && g < 100) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_wait: Busy still %b after %0d cycles, required 0", Busy, g);
    end
    Op = op; A = a; B = b; Start = 1'b1;
    start_in_done = Done;
    @(posedge Clk);
    #1;
    if (!keep) Start = 1'b0;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.acc = cyc;
    scb.push_back(e);
  endtask

  task automatic issue_r(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit keep);
    logic [31:0] h, l;
    logic d;
    model(op, a, b, h, l, d);
    issue(op, a, b, keep, h, l, d);
  endtask

  // Monitor: protocol invariants every cycle, result check on every Done
  always @(negedge Clk) begin
    exp_t e;
    chk("busy_and_done", {63'd0, Busy & Done}, 64'd0);
    chk("hild_eq_done", {63'd0, HiLd}, {63'd0, Done});
    chk("lold_eq_done", {63'd0, LoLd}, {63'd0, Done});
    chk("done_single_cycle", {63'd0, prev_done & Done}, 64'd0);
    if (!Done) chk("divzero_without_done", {63'd0, DivZero}, 64'd0);
    prev_done = Done;
    if (Done) begin
      if (scb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: Done=1 with no outstanding operation (cycle %0d)", cyc);
      end else begin
        e = scb.pop_front();
        chk("hi_out", {32'd0, HiOut}, {32'd0, e.hi});
        chk("lo_out", {32'd0, LoOut}, {32'd0, e.lo});
        chk("div_zero", {63'd0, DivZero}, {63'd0, e.dz});
        chk("latency", 64'(cyc - e.acc), 64'd33);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, g;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    Clr = 1'b1; Start = 1'b0; Op = 2'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge Clk);
    #1 Clr = 1'b0;
    @(negedge Clk);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_divzero", {63'd0, DivZero}, 64'd0);
    chk("rst_hi", {32'd0, HiOut}, 64'd0);
    chk("rst_lo", {32'd0, LoOut}, 64'd0);

    // Directed vectors with hand-derived results
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    chk("b2b_accept_in_done", {63'd0, start_in_done}, 64'd1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0, 32'h1, 1'b0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'd3, 32'd100, 32'd7, 0, 32'd2, 32'd14, 1'b0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 1'b0);
    issue(2'd3, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);

    // Clear in the middle of an operation
    issue_r(2'd1, 32'h0001_0203, 32'h0405_0607, 0);
    repeat (10) @(negedge Clk);
    Clr = 1'b1;
    scb.delete();
    @(posedge Clk);
    #1 Clr = 1'b0;
    @(negedge Clk);
    chk("clr_busy", {63'd0, Busy}, 64'd0);
    chk("clr_hi", {32'd0, HiOut}, 64'd0);
    chk("clr_lo", {32'd0, LoOut}, 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    chk("no_done_after_clr", 64'(nd), 64'd0);
    issue(2'd1, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1'b0);

    // Start held high with operands churning while busy
    issue_r(2'd2, 32'hFFFF_8000, 32'd123, 1);
    for (int i = 0; i < 33; i++) begin
      @(negedge Clk);
      A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
      chk("busy_while_held", {63'd0, Busy}, 64'd1);
    end
    @(negedge Clk);
    chk("held_done_cycle", {63'd0, Done}, 64'd1);
    Start = 1'b0;

    // Randomized operations, all issued back-to-back
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
        default: ;
      endcase
      issue_r(rop, ra, rb, 0);
    end

    g = 0;
    while (scb.size() > 0 && g < 200) begin
      @(negedge Clk);
      g++;
    end
    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", 64'(scb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit executing MULT, MULTU, DIV and DIVU for the pipelined MIPS datapath. It sits directly upstream of the HI and LO registers. It presents a 64-bit result as HiOut/LoOut together with one-cycle load strobes that drive the registers' Ld inputs. The pipeline controller starts an operation with Start and uses Busy to stall subsequent MFHI/MFLO/MULT/DIV instructions.

## Interface
- No parameters; datapath width fixed at 32 bits, iteration count fixed at 32.
- Clk  in  1  system clock; all state updates on rising edge.
- Clr  in  1  synchronous active-high reset; clears all state at the rising edge where it is sampled high.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A  in  32  multiplicand / dividend (rs).
- B  in  32  multiplier / divisor (rt).
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse; HiOut/LoOut valid this cycle.
- HiLd  out  1  one-cycle HI register load strobe, identical to Done.
- LoLd  out  1  one-cycle LO register load strobe, identical to Done.
- DivZero  out  1  one-cycle pulse with Done when a DIV/DIVU had B == 0.
- HiOut  out  32  product[63:32] or remainder.
- LoOut  out  32  product[31:0] or quotient.

## Operation
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on Start = 1.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- On acceptance, Op, A and B are latched internally. Changes on A/B/Op after acceptance have no effect.
- Signed ops:
  - Operate on absolute values; record result signs.
  - Multiply: product negated if sign(A) != sign(B).
  - Divide: quotient negated if sign(A) != sign(B); remainder takes the sign of A (truncation toward zero).
- MULT/MULTU: shift-add, one multiplier bit per CALC cycle; 64-bit accumulator.
- DIV/DIVU: restoring division, one quotient bit per CALC cycle; 33-bit partial remainder.
- FIX cycle:
  - Applies sign correction.
  - Registers HiOut/LoOut.
  - Asserts Done/HiLd/LoLd for exactly the following cycle.
- Divide by zero (B == 0, both DIV and DIVU):
  - LoOut = 32'hFFFFFFFF, HiOut = A as latched; DivZero = 1.
  - Same latency as a normal divide.
- Signed overflow, 32'h80000000 / 32'hFFFFFFFF: LoOut = 32'h80000000, HiOut = 0 (two's-complement wrap); no flag.
- HiOut/LoOut hold their last value until the next completion or Clr.
- Start while Busy is ignored. No queueing.

## Timing
- Reset values (Clr sampled high at any edge, including mid-operation):
  - State IDLE, iteration counter 0.
  - Busy = Done = HiLd = LoLd = DivZero = 0.
  - HiOut = LoOut = 0.
  - Any in-flight operation is discarded and produces no Done. Clr has priority over Start.
- Start sampled high at edge E0 (state IDLE):
  - Busy = 1 from after E0.
  - Iterations occur at edges E1..E32.
  - FIX completes at E33.
  - Done/HiLd/LoLd/DivZero are high from E33 to E34; Busy = 0 from E33.
- Fixed latency of 33 cycles, Start-accept to Done, for every Op and operand value.
- Done cycle: the unit is in IDLE, so Start = 1 in that cycle is accepted (back-to-back operations; the next Done arrives 33 cycles later).
- Done and the load strobes are never high for more than one consecutive cycle.
- Busy and Done are never high in the same cycle.

## Test plan
- MULT, A = 32'hFFFFFFFD (−3), B = 7 -> Done exactly 33 cycles after accept; HiOut = 32'hFFFFFFFF, LoOut = 32'hFFFFFFEB; HiLd = LoLd = 1 for one cycle.
- MULTU, A = B = 32'hFFFFFFFF -> HiOut = 32'hFFFFFFFE, LoOut = 32'h00000001. Then MULT on the same operands -> HiOut = 0, LoOut = 1.
- Divides:
  - DIV, A = 32'hFFFFFFF9 (−7), B = 2 -> LoOut = 32'hFFFFFFFD, HiOut = 32'hFFFFFFFF.
  - DIVU, A = 100, B = 7 -> LoOut = 14, HiOut = 2.
  - DIV, 32'h80000000 / 32'hFFFFFFFF -> LoOut = 32'h80000000, HiOut = 0.
- DIVU, A = 32'h00001234, B = 0 -> LoOut = 32'hFFFFFFFF, HiOut = 32'h00001234, DivZero = 1 with Done, 33-cycle latency.
- Clr mid-operation: assert Clr for one cycle 10 cycles after accept -> next cycle Busy = 0, HiOut = LoOut = 0; no Done in the following 40 cycles. A subsequent MULTU 6 × 7 -> LoOut = 42, HiOut = 0.
- Handshake:
  - Hold Start = 1 and change A/B every cycle during Busy -> result reflects only the operands latched at accept; no extra operation starts while Busy.
  - Start = 1 in the Done cycle -> second operation accepted; its Done arrives 33 cycles later.
